mult_div_unit: RTL and testbench

//   Iterative multiply/divide unit owning the HI/LO register pair; the multi-cycle successor to the ALU's single-cycle Mul/Div path.

---
 rtl/mult_div_unit.sv | 150 +++++++++++++++
 tb/tb_mult_div_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair (shift-add MUL, restoring DIV).
// Define MDU_FAST_MUL_EN to compute MUL in one cycle with a combinational product (DIV unchanged).
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             Div,
  input  logic             Unsigned,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             WriteHi,
  input  logic             WriteLo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             div_q, neg_p_q, neg_r_q, dz_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, b_q, raw_a_q;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] quot, rem;

  // Operands are reduced to magnitudes at start; signs are re-applied in FIX.
  assign neg_a = !Unsigned && op1[WIDTH-1];
  assign neg_b = !Unsigned && op2[WIDTH-1];
  assign a_mag = neg_a ? -op1 : op1;
  assign b_mag = neg_b ? -op2 : op2;

  // acc_hi/acc_lo double as {partial product, multiplier} or {remainder, dividend/quotient}.
  assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? b_q : '0)};
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};

`ifdef MDU_FAST_MUL_EN
  assign prod = {{WIDTH{1'b0}}, acc_lo_q} * {{WIDTH{1'b0}}, b_q};
`else
  assign prod = {acc_hi_q, acc_lo_q};
`endif
  assign prod_s = neg_p_q ? -prod : prod;
  assign quot   = neg_p_q ? -acc_lo_q : acc_lo_q;
  assign rem    = neg_r_q ? -acc_hi_q : acc_hi_q;

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) begin
`ifdef MDU_FAST_MUL_EN
        state_d = Div ? CALC : FIX;
`else
        state_d = CALC;
`endif
      end
      CALC:    if (cnt_q == CW'(1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt_q       <= '0;
      div_q       <= 1'b0;
      neg_p_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      dz_q        <= 1'b0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      b_q         <= '0;
      raw_a_q     <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            div_q    <= Div;
            neg_p_q  <= neg_a ^ neg_b;
            neg_r_q  <= neg_a;
            dz_q     <= Div && (op2 == '0);
            raw_a_q  <= op1;
            b_q      <= b_mag;
            acc_lo_q <= a_mag;
            acc_hi_q <= '0;
            cnt_q    <= CW'(WIDTH);
          end else begin
            if (WriteHi) hi <= op1;
            if (WriteLo) lo <= op1;
          end
        end
        CALC: begin
          cnt_q <= cnt_q - CW'(1);
          if (div_q) begin
            if (!div_diff[WIDTH]) begin
              acc_hi_q <= div_diff[WIDTH-1:0];
              acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi_q <= div_shift[WIDTH-1:0];
              acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi_q <= mul_sum[WIDTH:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (div_q) begin
            if (dz_q) begin
              hi          <= raw_a_q;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              hi <= rem;
              lo <= quot;
            end
          end else begin
            {hi, lo} <= prod_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases, control hazards, mid-op reset, random ops.
// Expected HI/LO come from a plain-arithmetic model; honours MDU_FAST_MUL_EN for MUL latency.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start, Div, Unsigned, WriteHi, WriteLo;
  logic [W-1:0] op1, op2;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .Div(Div), .Unsigned(Unsigned),
    .op1(op1), .op2(op2), .WriteHi(WriteHi), .WriteLo(WriteLo),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic d, input logic u, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] h,
                                output logic [W-1:0] l, output logic z);
    logic [63:0] p;
    logic signed [63:0] sa, sb, q, r;
    z = 1'b0;
    if (!d) begin
      if (u) p = {32'b0, a} * {32'b0, b};
      else   p = longint'($signed(a)) * longint'($signed(b));
      h = p[63:32];
      l = p[31:0];
    end else if (b == '0) begin
      z = 1'b1;
      h = a;
      l = '1;
    end else if (u) begin
      l = a / b;
      h = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      l = q[31:0];
      h = r[31:0];
    end
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Drives one start cycle; returns at the first negedge after the accepting edge.
  task automatic start_op(input logic d, input logic u, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic wh, input logic wl);
    logic [W-1:0] eh, el;
    logic ez;
    @(negedge clk);
    Div = d; Unsigned = u; op1 = a; op2 = b; start = 1'b1; WriteHi = wh; WriteLo = wl;
    model(d, u, a, b, eh, el, ez);
    exp_q.push_back(eh);
    exp_q.push_back(el);
    exp_q.push_back({{(W-1){1'b0}}, ez});
    @(negedge clk);
    start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
    op1 = $urandom; op2 = $urandom; Div = $urandom; Unsigned = $urandom;
  endtask

  // Waits for done (bounded), checks latency, busy span and results; inj>=0 pokes start/WriteHi mid-op.
  task automatic wait_done(input string tag, input logic d, input int inj);
    int n = 0;
    int bc = 0;
    int lat;
    logic [W-1:0] eh, el, ez;
`ifdef MDU_FAST_MUL_EN
    lat = d ? W + 1 : 1;
`else
    lat = W + 1;
`endif
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) bc++;
      if (n == inj) begin
        start = 1'b1; WriteHi = 1'b1; op1 = 32'd1; op2 = 32'd1;
      end else begin
        start = 1'b0; WriteHi = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0; WriteHi = 1'b0;
    eh = exp_q.pop_front();
    el = exp_q.pop_front();
    ez = exp_q.pop_front();
    check({tag, ".done"}, done, 1'b1);
    check({tag, ".latency"}, n, lat);
    check({tag, ".busy_cycles"}, bc, lat);
    check({tag, ".busy_at_done"}, busy, 1'b0);
    check({tag, ".hi"}, hi, eh);
    check({tag, ".lo"}, lo, el);
    check({tag, ".dz"}, div_by_zero, ez[0]);
    @(negedge clk);
    check({tag, ".done_pulse"}, done, 1'b0);
    check({tag, ".dz_pulse"}, div_by_zero, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic d, input logic u,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    start_op(d, u, a, b, 1'b0, 1'b0);
    wait_done(tag, d, -1);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; Div = 1'b0; Unsigned = 1'b0;
    WriteHi = 1'b0; WriteLo = 1'b0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.hi", hi, 0);
    check("reset.lo", lo, 0);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.dz", div_by_zero, 0);
    reset_n = 1'b1;

    run_op("mult_neg", 0, 0, 32'd28562, -32'sd292);
    run_op("div_pn", 1, 0, 32'd2452, -32'sd24);
    run_op("div_np", 1, 0, -32'sd2452, 32'd24);
    run_op("div_nn", 1, 0, -32'sd2452, -32'sd24);
    run_op("divu_small", 1, 1, 32'd572, 32'd5294);
    run_op("multu_max", 0, 1, 32'hFFFF_FFFF, 32'd2);
    run_op("div_zero", 1, 0, 32'd100, 32'd0);
    run_op("divu_zero", 1, 1, 32'hDEAD_BEEF, 32'd0);
    run_op("div_ovf", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mult_pos", 0, 0, 32'd28562, 32'd292);

    // Start and WriteHi while busy are ignored.
    start_op(0, 0, 32'd7, 32'd9, 1'b0, 1'b0);
    wait_done("hazard", 0, 5);
    op1 = 32'd3576; WriteHi = 1'b1;
    @(negedge clk);
    WriteHi = 1'b0;
    check("mthi.hi", hi, 32'd3576);
    check("mthi.lo", lo, 32'd63);
    op1 = 32'h1234_5678; WriteHi = 1'b1; WriteLo = 1'b1;
    @(negedge clk);
    WriteHi = 1'b0; WriteLo = 1'b0;
    check("mthilo.hi", hi, 32'h1234_5678);
    check("mthilo.lo", lo, 32'h1234_5678);
    start_op(0, 1, 32'd2, 32'd3, 1'b0, 1'b1);
    check("start_wins.lo", lo, 32'h1234_5678);
    check("start_wins.busy", busy, 1'b1);
    wait_done("start_wins", 0, -1);

    // Reset aborts an operation in flight.
    start_op(1, 0, 32'd1000, 32'd7, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    check("midreset.busy", busy, 0);
    check("midreset.done", done, 0);
    check("midreset.hi", hi, 0);
    check("midreset.lo", lo, 0);
    run_op("after_reset", 1, 0, -32'sd1000, 32'd7);

    for (int i = 0; i < 30; i++) begin
      logic d, u;
      d = $urandom_range(0, 1);
      u = $urandom_range(0, 1);
      run_op($sformatf("rand%0d", i), d, u, pick(), pick());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
